// File: rtl/lsm_defs.sv
// Shared definitions for the LSM sample sequencer: state encodings, register map
// and the transaction command record handed to the I2C handshake controller.
package lsm_defs;

  localparam logic [7:0] DEF_DEV_ADDR   = 8'hD4;
  localparam logic [7:0] REG_CTRL1      = 8'h20;
  localparam logic [7:0] DEF_CTRL1_VAL  = 8'h57;
  localparam logic [7:0] REG_OUT_X_L    = 8'h28;
  localparam logic [7:0] REG_WHO_AM_I   = 8'h0F;
  localparam logic [7:0] WHOAMI_VAL     = 8'h33;
  localparam int         DEF_SAMPLE_DIV = 500000;
  localparam int         DEF_TIMEOUT    = 100000;
  localparam int         NUM_BYTES      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WHOAMI,
    ST_WHOAMI_WAIT,
    ST_CFG,
    ST_WAIT_TICK,
    ST_RD,
    ST_PUBLISH
  } seq_state_e;

  typedef enum logic [1:0] {
    TXN_IDLE,
    TXN_BUSY,
    TXN_GAP
  } txn_state_e;

  typedef struct packed {
    logic       rw;
    logic [7:0] reg_addr;
    logic [7:0] tx;
  } i2c_cmd_t;

  function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/lsm_txn_ctrl.sv
// One I2C byte-master transaction: latches the command, holds i2c_en until the
// rising edge of i2c_done or a timeout, captures rx, then inserts a one-cycle gap.
module lsm_txn_ctrl
  import lsm_defs::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  i2c_cmd_t   cmd,
  output logic       ready,
  output logic       i2c_en,
  output logic       i2c_rw,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_tx,
  input  logic [7:0] i2c_rx,
  input  logic       i2c_done,
  output logic [7:0] rx_data,
  output logic       done,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  txn_state_e    state_q, state_d;
  logic [TW-1:0] cnt_q;
  logic          done_d;
  logic          done_edge;
  logic          expired;

  assign done_edge = i2c_done & ~done_d;
  assign expired   = (cnt_q == TW'(TIMEOUT - 1));
  assign ready     = (state_q == TXN_IDLE);

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TXN_IDLE: if (start) state_d = TXN_BUSY;
      TXN_BUSY: if (done_edge || expired) state_d = TXN_GAP;
      TXN_GAP:  state_d = TXN_IDLE;
      default:  state_d = TXN_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= TXN_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i2c_en       <= 1'b0;
      i2c_rw       <= 1'b0;
      i2c_reg_addr <= 8'h00;
      i2c_tx       <= 8'h00;
      rx_data      <= 8'h00;
      done         <= 1'b0;
      timeout      <= 1'b0;
      done_d       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      done_d  <= i2c_done;
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state_q)
        TXN_IDLE: begin
          if (start) begin
            i2c_en       <= 1'b1;
            i2c_rw       <= cmd.rw;
            i2c_reg_addr <= cmd.reg_addr;
            i2c_tx       <= cmd.tx;
            cnt_q        <= '0;
          end
        end
        TXN_BUSY: begin
          // A done edge in the expiry cycle still completes the transfer.
          if (done_edge) begin
            i2c_en  <= 1'b0;
            rx_data <= i2c_rx;
            done    <= 1'b1;
          end else if (expired) begin
            i2c_en  <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsm_sample_sequencer.sv
// Configures the LSM accelerometer once, then reads the six output bytes on every
// sample tick and publishes signed X/Y/Z. Build option: LSM_WHOAMI_CHECK_EN.
module lsm_sample_sequencer
  import lsm_defs::*;
#(
  parameter logic [7:0] DEV_ADDR   = DEF_DEV_ADDR,
  parameter logic [7:0] CTRL1_ADDR = REG_CTRL1,
  parameter logic [7:0] CTRL1_VAL  = DEF_CTRL1_VAL,
  parameter logic [7:0] OUT_BASE   = REG_OUT_X_L,
  parameter int         SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int         TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2c_en,
  output logic        i2c_rw,
  output logic [7:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_tx,
  input  logic [7:0]  i2c_rx,
  input  logic        i2c_done,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic        sample_valid,
  output logic        err_timeout,
  output logic        overrun
);

  localparam int CW = $clog2(SAMPLE_DIV);

  seq_state_e    state_q, state_d;
  logic [2:0]    idx_q;
  logic [7:0]    byte_buf [NUM_BYTES];
  logic [CW-1:0] tick_cnt_q;
  logic          tick_run_q;
  logic          tick;
  logic          whoami_bad;

  i2c_cmd_t      cmd;
  logic          txn_start, txn_ready, txn_done, txn_timeout;
  logic [7:0]    txn_rx;

`ifdef LSM_WHOAMI_CHECK_EN
  localparam seq_state_e FIRST_STATE = ST_WHOAMI;
  logic [CW-1:0] retry_cnt_q;
  logic          retry_expire;
  assign retry_expire = (state_q == ST_WHOAMI_WAIT) && (retry_cnt_q == CW'(SAMPLE_DIV - 1));
`else
  localparam seq_state_e FIRST_STATE = ST_CFG;
`endif

  assign i2c_dev_addr = DEV_ADDR;
  assign tick         = tick_run_q && (tick_cnt_q == CW'(SAMPLE_DIV - 1));

  lsm_txn_ctrl #(.TIMEOUT(TIMEOUT)) u_txn (
    .clk          (clk),
    .rst          (rst),
    .start        (txn_start),
    .cmd          (cmd),
    .ready        (txn_ready),
    .i2c_en       (i2c_en),
    .i2c_rw       (i2c_rw),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_tx       (i2c_tx),
    .i2c_rx       (i2c_rx),
    .i2c_done     (i2c_done),
    .rx_data      (txn_rx),
    .done         (txn_done),
    .timeout      (txn_timeout)
  );

  // A new transaction is only requested between transfers, so a falling enable
  // lets the current one finish before the sequencer parks in IDLE.
  always_comb begin
    state_d    = state_q;
    txn_start  = 1'b0;
    whoami_bad = 1'b0;
    cmd        = '{rw: 1'b0, reg_addr: 8'h00, tx: 8'h00};
    unique case (state_q)
      ST_IDLE: if (enable) state_d = FIRST_STATE;
`ifdef LSM_WHOAMI_CHECK_EN
      ST_WHOAMI: begin
        cmd = '{rw: 1'b0, reg_addr: REG_WHO_AM_I, tx: 8'h00};
        if (txn_done) begin
          whoami_bad = (txn_rx != WHOAMI_VAL);
          if (!enable)         state_d = ST_IDLE;
          else if (whoami_bad) state_d = ST_WHOAMI_WAIT;
          else                 state_d = ST_CFG;
        end else if (txn_timeout) begin
          state_d = enable ? ST_WHOAMI_WAIT : ST_IDLE;
        end else if (txn_ready) begin
          if (enable) txn_start = 1'b1;
          else        state_d   = ST_IDLE;
        end
      end
      ST_WHOAMI_WAIT: begin
        if (!enable)           state_d = ST_IDLE;
        else if (retry_expire) state_d = ST_WHOAMI;
      end
`endif
      ST_CFG: begin
        cmd = '{rw: 1'b1, reg_addr: CTRL1_ADDR, tx: CTRL1_VAL};
        if (txn_done) begin
          state_d = enable ? ST_WAIT_TICK : ST_IDLE;
        end else if (txn_timeout) begin
          state_d = enable ? ST_CFG : ST_IDLE;
        end else if (txn_ready) begin
          if (enable) txn_start = 1'b1;
          else        state_d   = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (!enable)   state_d = ST_IDLE;
        else if (tick) state_d = ST_RD;
      end
      ST_RD: begin
        cmd = '{rw: 1'b0, reg_addr: OUT_BASE + {5'b00000, idx_q}, tx: 8'h00};
        if (txn_done) begin
          if (!enable)                           state_d = ST_IDLE;
          else if (idx_q == 3'(NUM_BYTES - 1))   state_d = ST_PUBLISH;
        end else if (txn_timeout) begin
          state_d = enable ? ST_CFG : ST_IDLE;
        end else if (txn_ready) begin
          if (enable) txn_start = 1'b1;
          else        state_d   = ST_IDLE;
        end
      end
      ST_PUBLISH: state_d = enable ? ST_WAIT_TICK : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the byte buffer has no reset; it is fully rewritten before every PUBLISH, so stale bytes never escape.
  always_ff @(posedge clk) begin
    if (state_q == ST_RD && txn_done) byte_buf[idx_q] <= txn_rx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= 3'd0;
      tick_cnt_q   <= '0;
      tick_run_q   <= 1'b0;
      acc_x        <= 16'h0000;
      acc_y        <= 16'h0000;
      acc_z        <= 16'h0000;
      sample_valid <= 1'b0;
      err_timeout  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= (state_q == ST_PUBLISH);
      err_timeout  <= txn_timeout | whoami_bad;

      if (state_q == ST_PUBLISH) begin
        acc_x <= join_bytes(byte_buf[1], byte_buf[0]);
        acc_y <= join_bytes(byte_buf[3], byte_buf[2]);
        acc_z <= join_bytes(byte_buf[5], byte_buf[4]);
      end

      if (state_d != ST_RD)  idx_q <= 3'd0;
      else if (state_q == ST_RD && txn_done) idx_q <= idx_q + 3'd1;

      // The tick grid restarts from zero each time CFG completes.
      if (state_d == ST_IDLE) begin
        tick_run_q <= 1'b0;
        tick_cnt_q <= '0;
      end else if (state_q == ST_CFG && txn_done) begin
        tick_run_q <= 1'b1;
        tick_cnt_q <= '0;
      end else if (tick_run_q) begin
        tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
      end

      if (tick && (state_q == ST_RD || state_q == ST_PUBLISH)) overrun <= 1'b1;
    end
  end

`ifdef LSM_WHOAMI_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WHOAMI_WAIT) retry_cnt_q <= '0;
    else                                  retry_cnt_q <= retry_cnt_q + CW'(1);
  end
`endif

endmodule

// File: tb/tb_lsm_sample_sequencer.sv
// Scoreboard bench: an I2C slave model logs every transaction it sees; each test
// queues the transactions and samples it expects and compares them in order.
module tb_lsm_sample_sequencer;

  localparam int DIV = 64;
  localparam int TMO = 48;
`ifdef LSM_WHOAMI_CHECK_EN
  localparam bit WHOAMI_EN = 1'b1;
`else
  localparam bit WHOAMI_EN = 1'b0;
`endif

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] tx;
  } txn_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        i2c_en, i2c_rw;
  logic [7:0]  i2c_dev_addr, i2c_reg_addr, i2c_tx;
  logic [7:0]  i2c_rx = 8'h00;
  logic        i2c_done = 1'b0;
  logic [15:0] acc_x, acc_y, acc_z;
  logic        sample_valid, err_timeout, overrun;

  always #5 clk = ~clk;

  lsm_sample_sequencer #(.SAMPLE_DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2c_en       (i2c_en),
    .i2c_rw       (i2c_rw),
    .i2c_dev_addr (i2c_dev_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_tx       (i2c_tx),
    .i2c_rx       (i2c_rx),
    .i2c_done     (i2c_done),
    .acc_x        (acc_x),
    .acc_y        (acc_y),
    .acc_z        (acc_z),
    .sample_valid (sample_valid),
    .err_timeout  (err_timeout),
    .overrun      (overrun)
  );

  txn_t       obs_q[$], exp_q[$];
  smp_t       smp_q[$];
  int         len_q[$];
  int         passed = 0, total = 0;
  logic [7:0] mem [256];
  int         model_delay = 2;
  bit         model_silent = 1'b0;
  bit         busy = 1'b0;
  int         cnt = 0, en_len = 0;
  int         err_cnt = 0, smp_cnt = 0, burst_cnt = 0;

  // I2C slave model and output monitors, evaluated on the falling edge.
  always @(negedge clk) begin
    if (i2c_en !== 1'b1) begin
      if (busy) len_q.push_back(en_len);
      i2c_done = 1'b0;
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy = 1'b1;
        cnt = model_delay;
        en_len = 0;
        obs_q.push_back('{i2c_rw, i2c_reg_addr, i2c_tx});
      end
      en_len++;
      if (!model_silent && !i2c_done) begin
        if (cnt == 0) begin
          i2c_done = 1'b1;
          i2c_rx = mem[i2c_reg_addr];
          if (i2c_rw) mem[i2c_reg_addr] = i2c_tx;
          if (i2c_reg_addr == 8'h2D) burst_cnt++;
        end else begin
          cnt--;
        end
      end
    end
    if (sample_valid === 1'b1) begin
      smp_q.push_back('{acc_x, acc_y, acc_z});
      smp_cnt++;
    end
    if (err_timeout === 1'b1) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic push_restart();
    if (WHOAMI_EN) exp_q.push_back('{1'b0, 8'h0F, 8'h00});
    exp_q.push_back('{1'b1, 8'h20, 8'h57});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (i2c_en !== 1'b0) $display("FAIL reset_en: got %b want 0", i2c_en); else passed++;
    total++; if (i2c_rw !== 1'b0) $display("FAIL reset_rw: got %b want 0", i2c_rw); else passed++;
    total++; if ({i2c_reg_addr, i2c_tx} !== 16'h0000) $display("FAIL reset_addr_tx: got %h want 0000", {i2c_reg_addr, i2c_tx}); else passed++;
    total++; if (i2c_dev_addr !== 8'hD4) $display("FAIL reset_dev_addr: got %h want d4", i2c_dev_addr); else passed++;
    total++; if ({acc_x, acc_y, acc_z} !== 48'h0) $display("FAIL reset_acc: got %h want 0", {acc_x, acc_y, acc_z}); else passed++;
    total++; if ({sample_valid, err_timeout, overrun} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {sample_valid, err_timeout, overrun}); else passed++;
  endtask

  task automatic test_cfg();
    txn_t e, o;
    obs_q.delete();
    push_restart();
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL cfg_txn: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL cfg_txn: got %h want %h", o, e); else passed++;
      end
    end
    repeat (DIV - 20) begin @(posedge clk); #1; end
    total++; if (obs_q.size() != 0) $display("FAIL cfg_quiet: got %0d txns want 0", obs_q.size()); else passed++;
  endtask

  task automatic test_sample(input string name, input logic [47:0] bytes,
                             input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez);
    txn_t e, o;
    smp_t s, es;
    for (int k = 0; k < 6; k++) begin
      mem[8'h28 + k] = bytes[8*k +: 8];
      exp_q.push_back('{1'b0, 8'(8'h28 + k), 8'h00});
    end
    es = '{ex, ey, ez};
    for (int i = 0; i < 400 && smp_q.size() == 0; i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL %s_txn: got none want %h", name, e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL %s_txn: got %h want %h", name, o, e); else passed++;
      end
    end
    total++;
    if (smp_q.size() == 0) $display("FAIL %s_sample: got none want %h", name, es);
    else begin
      s = smp_q.pop_front();
      if (s !== es) $display("FAIL %s_sample: got %h want %h", name, s, es); else passed++;
    end
    repeat (5) begin @(posedge clk); #1; end
    total++; if (smp_q.size() != 0) $display("FAIL %s_single_pulse: got %0d extra want 0", name, smp_q.size()); else passed++;
  endtask

  task automatic test_timeout();
    txn_t e, o;
    int e0, s0;
    e0 = err_cnt;
    s0 = smp_cnt;
    len_q.delete();
    model_silent = 1'b1;
    for (int i = 0; i < DIV + TMO + 50 && err_cnt == e0; i++) begin @(posedge clk); #1; end
    model_silent = 1'b0;
    exp_q.push_back('{1'b0, 8'h28, 8'h00});
    exp_q.push_back('{1'b1, 8'h20, 8'h57});
    for (int i = 0; i < 50 && obs_q.size() < 2; i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL timeout_txn: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL timeout_txn: got %h want %h", o, e); else passed++;
      end
    end
    total++;
    if (len_q.size() == 0) $display("FAIL timeout_len: got none want %0d", TMO);
    else if (len_q[0] != TMO) $display("FAIL timeout_len: got %0d want %0d", len_q[0], TMO);
    else passed++;
    repeat (10) begin @(posedge clk); #1; end
    total++; if (err_cnt != e0 + 1) $display("FAIL timeout_err_pulse: got %0d want %0d", err_cnt - e0, 1); else passed++;
    total++; if (smp_cnt != s0) $display("FAIL timeout_no_sample: got %0d want 0", smp_cnt - s0); else passed++;
  endtask

  task automatic test_overrun();
    smp_t s, es;
    int s0, d0;
    es = '{{mem[8'h29], mem[8'h28]}, {mem[8'h2B], mem[8'h2A]}, {mem[8'h2D], mem[8'h2C]}};
    total++; if (overrun !== 1'b0) $display("FAIL overrun_pre: got %b want 0", overrun); else passed++;
    model_delay = 20;
    s0 = smp_cnt;
    d0 = burst_cnt;
    for (int i = 0; i < 1500 && overrun !== 1'b1; i++) begin @(posedge clk); #1; end
    total++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else passed++;
    for (int i = 0; i < 1500 && smp_cnt < s0 + 2; i++) begin @(posedge clk); #1; end
    total++;
    if (smp_cnt - s0 < 2 || smp_cnt - s0 != burst_cnt - d0)
      $display("FAIL overrun_pulses: got %0d samples want %0d (completed bursts)", smp_cnt - s0, burst_cnt - d0);
    else passed++;
    while (smp_q.size() > 0) begin
      s = smp_q.pop_front();
      total++; if (s !== es) $display("FAIL overrun_sample: got %h want %h", s, es); else passed++;
    end
    total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else passed++;
  endtask

  task automatic test_disable();
    txn_t e, o;
    int s0;
    logic [47:0] ea;
    ea = {mem[8'h29], mem[8'h28], mem[8'h2B], mem[8'h2A], mem[8'h2D], mem[8'h2C]};
    enable = 1'b0;
    repeat (60) begin @(posedge clk); #1; end
    obs_q.delete();
    smp_q.delete();
    s0 = smp_cnt;
    repeat (150) begin @(posedge clk); #1; end
    total++; if (obs_q.size() != 0) $display("FAIL disable_quiet: got %0d txns want 0", obs_q.size()); else passed++;
    total++; if (i2c_en !== 1'b0) $display("FAIL disable_en: got %b want 0", i2c_en); else passed++;
    total++; if (smp_cnt != s0) $display("FAIL disable_no_sample: got %0d want 0", smp_cnt - s0); else passed++;
    total++; if ({acc_x, acc_y, acc_z} !== ea) $display("FAIL disable_acc_kept: got %h want %h", {acc_x, acc_y, acc_z}, ea); else passed++;
    model_delay = 2;
    push_restart();
    enable = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL reenable_txn: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL reenable_txn: got %h want %h", o, e); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    txn_t e, o;
    bit found;
    int s0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk); #1;
      while (obs_q.size() > 0 && !found) begin
        o = obs_q.pop_front();
        if (o.addr == 8'h2B) found = 1'b1;
      end
    end
    total++; if (!found) $display("FAIL rstmid_reach_k3: got no read of 2b want one"); else passed++;
    s0 = smp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (i2c_en !== 1'b0) $display("FAIL rstmid_en: got %b want 0", i2c_en); else passed++;
    total++; if ({acc_x, acc_y, acc_z} !== 48'h0) $display("FAIL rstmid_acc: got %h want 0", {acc_x, acc_y, acc_z}); else passed++;
    total++; if ({sample_valid, err_timeout, overrun} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {sample_valid, err_timeout, overrun}); else passed++;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    obs_q.delete();
    push_restart();
    for (int i = 0; i < 100 && obs_q.size() < exp_q.size(); i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL rstmid_restart: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL rstmid_restart: got %h want %h", o, e); else passed++;
      end
    end
    repeat (10) begin @(posedge clk); #1; end
    total++; if (smp_cnt != s0) $display("FAIL rstmid_no_sample: got %0d want 0", smp_cnt - s0); else passed++;
  endtask

`ifdef LSM_WHOAMI_CHECK_EN
  task automatic test_whoami();
    txn_t e, o;
    int e0;
    mem[8'h0F] = 8'h32;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    e0 = err_cnt;
    rst = 1'b0;
    obs_q.delete();
    exp_q.push_back('{1'b0, 8'h0F, 8'h00});
    for (int i = 0; i < 50 && err_cnt == e0; i++) begin @(posedge clk); #1; end
    total++; if (err_cnt != e0 + 1) $display("FAIL whoami_err: got %0d want 1", err_cnt - e0); else passed++;
    mem[8'h0F] = 8'h33;
    exp_q.push_back('{1'b0, 8'h0F, 8'h00});
    exp_q.push_back('{1'b1, 8'h20, 8'h57});
    for (int i = 0; i < DIV + 100 && obs_q.size() < 3; i++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL whoami_txn: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL whoami_txn: got %h want %h", o, e); else passed++;
      end
    end
  endtask
`endif

  initial begin
    logic [47:0] rnd;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    if (WHOAMI_EN) mem[8'h0F] = 8'h33;
    rnd = {$urandom, $urandom};
    test_reset();
    test_cfg();
    test_sample("sample_a", {8'h00, 8'h00, 8'h7F, 8'hFF, 8'h80, 8'h01}, 16'h8001, 16'h7FFF, 16'h0000);
    test_sample("sample_b", {8'hFF, 8'hFE, 8'hAB, 8'hCD, 8'h12, 8'h34}, 16'h1234, 16'hABCD, 16'hFFFE);
    test_timeout();
    test_sample("sample_rnd", rnd, rnd[15:0], rnd[31:16], rnd[47:32]);
    test_overrun();
    test_disable();
    test_reset_mid();
`ifdef LSM_WHOAMI_CHECK_EN
    test_whoami();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
